// File: rtl/mux_gate_reduce_pipe.sv
// Pipelined bitwise reducer: a binary tree of mux-built 2-input gates, one
// register level per tree level, with a valid bit and opcode per transaction.

module mux_gate_reduce_pipe_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module mux_gate_reduce_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           op,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    output logic [1:0]           out_op,
    output logic [WIDTH-1:0]     out_data
);
    localparam int unsigned L     = $clog2(N);
    localparam int unsigned NODES = N - 1;
    localparam int          NI    = int'(N);

    if (N < 2 || (N & (N - 1)) != 0) begin : gen_bad_n
        $error("mux_gate_reduce_pipe: N must be a power of 2 and at least 2");
    end

    // Tree nodes in heap order: node 1 is the root, node k has children 2k
    // and 2k+1; nodes N..2N-1 are the input channels themselves.
    logic [WIDTH-1:0] tree_q [1:NODES];
    logic [WIDTH-1:0] tree_d [1:NODES];
    logic [WIDTH-1:0] gate_y [1:NODES];
    logic [L:1]       vld_q;
    logic [L:1]       vld_d;
    logic [1:0]       op_q   [1:L];
    logic [1:0]       op_d   [1:L];

    // Valid/op feeding each stage: index s-1 feeds stage s, index 0 is the input.
    logic [L-1:0]     stage_vld;
    logic [1:0]       op_st  [0:L-1];

    always_comb begin
        stage_vld = '0;
        op_st     = '{default: '0};
        stage_vld[0] = in_valid;
        op_st[0]     = op;
        for (int s = 1; s < int'(L); s++) begin
            stage_vld[s] = vld_q[s];
            op_st[s]     = op_q[s];
        end
    end

    for (genvar k = 1; k <= NI - 1; k++) begin : gen_node
        localparam int unsigned DEPTH = $clog2(k + 1) - 1;
        localparam int unsigned S     = L - DEPTH;

        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic [1:0]       opc;

        assign opc = op_st[S-1];

        if (2 * k >= NI) begin : gen_leaf
            assign a = in_data[(2*k - NI) * WIDTH +: WIDTH];
            assign b = in_data[(2*k + 1 - NI) * WIDTH +: WIDTH];
        end else begin : gen_inner
            assign a = tree_q[2*k];
            assign b = tree_q[2*k + 1];
        end

        for (genvar j = 0; j < int'(WIDTH); j++) begin : gen_bit
            logic and_y;
            logic or_y;
            logic nb_y;
            logic xor_y;
            logic lo_y;
            logic hi_y;
            logic r_y;

            mux_gate_reduce_pipe_mux2 u_and (.d0(1'b0), .d1(b[j]),  .sel(a[j]), .y(and_y));
            mux_gate_reduce_pipe_mux2 u_or  (.d0(b[j]), .d1(1'b1),  .sel(a[j]), .y(or_y));
            mux_gate_reduce_pipe_mux2 u_nb  (.d0(1'b1), .d1(1'b0),  .sel(b[j]), .y(nb_y));
            mux_gate_reduce_pipe_mux2 u_xor (.d0(b[j]), .d1(nb_y),  .sel(a[j]), .y(xor_y));
            // op[0] picks within each half: 00 AND / 01 OR, 10 XOR / 11 AND (NAND)
            mux_gate_reduce_pipe_mux2 u_lo  (.d0(and_y), .d1(or_y),  .sel(opc[0]), .y(lo_y));
            mux_gate_reduce_pipe_mux2 u_hi  (.d0(xor_y), .d1(and_y), .sel(opc[0]), .y(hi_y));
            mux_gate_reduce_pipe_mux2 u_sel (.d0(lo_y),  .d1(hi_y),  .sel(opc[1]), .y(r_y));

            if (k == 1) begin : gen_root
                logic inv_y;
                logic is_nand;
                mux_gate_reduce_pipe_mux2 u_inv   (.d0(1'b1), .d1(1'b0),   .sel(r_y),    .y(inv_y));
                mux_gate_reduce_pipe_mux2 u_isnd  (.d0(1'b0), .d1(opc[0]), .sel(opc[1]), .y(is_nand));
                mux_gate_reduce_pipe_mux2 u_fin   (.d0(r_y),  .d1(inv_y),  .sel(is_nand), .y(y[j]));
            end else begin : gen_mid
                assign y[j] = r_y;
            end
        end

        assign gate_y[k] = y;
    end

    // Valids always shift; data and op load only behind a valid.
    always_comb begin
        vld_d  = '0;
        op_d   = op_q;
        tree_d = tree_q;
        for (int s = 1; s <= int'(L); s++) begin
            vld_d[s] = stage_vld[s-1];
            if (stage_vld[s-1]) begin
                op_d[s] = op_st[s-1];
            end
            for (int i = 0; i < (NI >> s); i++) begin
                if (stage_vld[s-1]) begin
                    tree_d[(NI >> s) + i] = gate_y[(NI >> s) + i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            op_q   <= '{default: '0};
            tree_q <= '{default: '0};
        end else begin
            vld_q  <= vld_d;
            op_q   <= op_d;
            tree_q <= tree_d;
        end
    end

    assign out_valid = vld_q[L];
    assign out_op    = op_q[L];
    assign out_data  = tree_q[1];

endmodule

// File: tb/tb_mux_gate_reduce_pipe.sv
// Bench for mux_gate_reduce_pipe: three instances (N=4/W=8, N=2/W=1, N=8/W=16)
// checked every cycle against a per-edge history model plus literal vectors.

module tb_mux_gate_reduce_pipe;
    localparam int MAXE = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         v4, v2, v8;
    logic [1:0]   op4, op2, op8;
    logic [31:0]  d4;
    logic [1:0]   d2;
    logic [127:0] d8;
    logic         ov4, ov2, ov8;
    logic [1:0]   oop4, oop2, oop8;
    logic [7:0]   od4;
    logic [0:0]   od2;
    logic [15:0]  od8;

    mux_gate_reduce_pipe #(.WIDTH(8), .N(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .op(op4), .in_data(d4),
        .out_valid(ov4), .out_op(oop4), .out_data(od4));
    mux_gate_reduce_pipe #(.WIDTH(1), .N(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .op(op2), .in_data(d2),
        .out_valid(ov2), .out_op(oop2), .out_data(od2));
    mux_gate_reduce_pipe #(.WIDTH(16), .N(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .op(op8), .in_data(d8),
        .out_valid(ov8), .out_op(oop8), .out_data(od8));

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    logic        h_rst [MAXE];
    logic        h_v   [3][MAXE];
    logic [1:0]  h_op  [3][MAXE];
    logic [15:0] h_res [3][MAXE];
    logic [1:0]  hold_op [3];
    logic [15:0] hold_d  [3];

    // Reference reduction over n channels of w bits with plain operators.
    function automatic logic [15:0] red(input logic [127:0] data, input int n,
                                        input int w, input logic [1:0] opc);
        logic [15:0] mask, r, c;
        mask = 16'((32'd1 << w) - 32'd1);
        r = 16'(data) & mask;
        for (int k = 1; k < n; k++) begin
            c = 16'(data >> (k * w)) & mask;
            case (opc)
                2'b01:   r = r | c;
                2'b10:   r = r ^ c;
                default: r = r & c;
            endcase
        end
        if (opc == 2'b11) r = ~r & mask;
        return r;
    endfunction

    // Record what each instance saw at every rising edge.
    initial forever begin
        @(posedge clk);
        if (edge_n < MAXE) begin
            h_rst[edge_n]    = rst;
            h_v[0][edge_n]   = v4;
            h_op[0][edge_n]  = op4;
            h_res[0][edge_n] = red({96'b0, d4}, 4, 8, op4);
            h_v[1][edge_n]   = v2;
            h_op[1][edge_n]  = op2;
            h_res[1][edge_n] = red({126'b0, d2}, 2, 1, op2);
            h_v[2][edge_n]   = v8;
            h_op[2][edge_n]  = op8;
            h_res[2][edge_n] = red(d8, 8, 16, op8);
        end
        edge_n++;
    end

    // Output after edge t is the input of edge t-lat+1, unless a reset edge
    // lies anywhere in that window; data/op hold the last valid result.
    task automatic cmp(input int idx, input int lat, input logic av,
                       input logic [1:0] aop, input logic [15:0] ad);
        int t, s;
        logic ev;
        t  = edge_n - 1;
        s  = t - lat + 1;
        ev = 1'b0;
        if (s >= 0 && h_v[idx][s]) begin
            ev = 1'b1;
            for (int e = s; e <= t; e++) if (h_rst[e]) ev = 1'b0;
        end
        if (h_rst[t]) begin
            hold_op[idx] = 2'b00;
            hold_d[idx]  = 16'h0;
        end else if (ev) begin
            hold_op[idx] = h_op[idx][s];
            hold_d[idx]  = h_res[idx][s];
        end
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL model_valid inst%0d edge%0d: got %b want %b", idx, t, av, ev);
        end
        checks++;
        if (aop !== hold_op[idx]) begin
            errors++;
            $display("FAIL model_op inst%0d edge%0d: got %b want %b", idx, t, aop, hold_op[idx]);
        end
        checks++;
        if (ad !== hold_d[idx]) begin
            errors++;
            $display("FAIL model_data inst%0d edge%0d: got %h want %h", idx, t, ad, hold_d[idx]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (edge_n > 0 && edge_n <= MAXE) begin
            cmp(0, 2, ov4, oop4, {8'b0, od4});
            cmp(1, 1, ov2, oop2, {15'b0, od2});
            cmp(2, 3, ov8, oop8, od8);
        end
    end

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        v4 = 1'b0; op4 = 2'b00; d4 = '0;
        v2 = 1'b0; op2 = 2'b00; d2 = '0;
        v8 = 1'b0; op8 = 2'b00; d8 = '0;
        step(); step();
        lit("reset_valid", 16'(ov4), 16'h0);
        lit("reset_data",  16'(od4), 16'h0);
        lit("reset_op",    16'(oop4), 16'h0);
        rst = 1'b0;
        step();

        // reset flush: an in-flight AND of all-ones must never surface
        v4 = 1'b1; op4 = 2'b00; d4 = 32'hFFFF_FFFF;
        step();
        v4 = 1'b0; rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            rst = 1'b0;
            lit($sformatf("flush_valid_%0d", i), 16'(ov4), 16'h0);
            lit($sformatf("flush_data_%0d", i),  16'(od4), 16'h0);
        end

        // AND then NAND on the same channels {FF,F0,3C,FF}
        v4 = 1'b1; op4 = 2'b00; d4 = 32'hFF3C_F0FF;
        step();
        lit("and_pre_valid", 16'(ov4), 16'h0);
        op4 = 2'b11;
        step();
        lit("and_valid", 16'(ov4), 16'h1);
        lit("and_data",  16'(od4), 16'h30);
        lit("and_op",    16'(oop4), 16'h0);
        v4 = 1'b0;
        step();
        lit("nand_valid", 16'(ov4), 16'h1);
        lit("nand_data",  16'(od4), 16'hCF);
        lit("nand_op",    16'(oop4), 16'h3);
        step();
        lit("nand_post_valid", 16'(ov4), 16'h0);
        lit("nand_post_hold",  16'(od4), 16'hCF);

        // OR {01,02,04,80} then XOR {FF,0F,F0,01}
        v4 = 1'b1; op4 = 2'b01; d4 = 32'h8004_0201;
        step();
        op4 = 2'b10; d4 = 32'h01F0_0FFF;
        step();
        lit("or_valid", 16'(ov4), 16'h1);
        lit("or_data",  16'(od4), 16'h87);
        lit("or_op",    16'(oop4), 16'h1);
        v4 = 1'b0;
        step();
        lit("xor_valid", 16'(ov4), 16'h1);
        lit("xor_data",  16'(od4), 16'h01);
        lit("xor_op",    16'(oop4), 16'h2);
        step();

        // bubble: valid, idle, valid
        v4 = 1'b1; op4 = 2'b01; d4 = 32'h8004_0201;
        step();
        v4 = 1'b0;
        step();
        lit("bub_valid_1", 16'(ov4), 16'h1);
        lit("bub_data_1",  16'(od4), 16'h87);
        v4 = 1'b1; op4 = 2'b00; d4 = 32'h0FFF_FFFF;
        step();
        v4 = 1'b0;
        lit("bub_valid_gap", 16'(ov4), 16'h0);
        lit("bub_hold_gap",  16'(od4), 16'h87);
        step();
        lit("bub_valid_2", 16'(ov4), 16'h1);
        lit("bub_data_2",  16'(od4), 16'h0F);
        step();
        lit("bub_valid_end", 16'(ov4), 16'h0);

        // N=2, WIDTH=1: truth table of AND at latency 1
        for (int i = 0; i < 4; i++) begin
            v2 = 1'b1; op2 = 2'b00; d2 = 2'(i);
            step();
            lit($sformatf("n2_valid_%0d", i), 16'(ov2), 16'h1);
            lit($sformatf("n2_and_%0d", i),   16'(od2), (i == 3) ? 16'h1 : 16'h0);
        end
        v2 = 1'b0;
        step();
        lit("n2_idle_valid", 16'(ov2), 16'h0);

        // N=8, WIDTH=16: XOR of one-hot channels, then NAND, latency 3
        v8 = 1'b1; op8 = 2'b10;
        d8 = {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001};
        step();
        op8 = 2'b11;
        d8 = {16'h7FFF, {7{16'hFFFF}}};
        step();
        v8 = 1'b0;
        lit("n8_lat_valid", 16'(ov8), 16'h0);
        step();
        lit("n8_xor_valid", 16'(ov8), 16'h1);
        lit("n8_xor_data",  od8, 16'h00FF);
        step();
        lit("n8_nand_data", od8, 16'h8000);
        lit("n8_nand_op",   16'(oop8), 16'h3);
        step(); step();

        // random traffic on all instances, with one reset mid-stream
        for (int c = 0; c < 300; c++) begin
            rst = (c == 150);
            v4  = 1'($urandom_range(0, 1));
            op4 = 2'($urandom_range(0, 3));
            d4  = $urandom;
            v2  = 1'($urandom_range(0, 1));
            op2 = 2'($urandom_range(0, 3));
            d2  = 2'($urandom_range(0, 3));
            v8  = 1'($urandom_range(0, 3) != 0);
            op8 = 2'($urandom_range(0, 3));
            d8  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst = 1'b0; v4 = 1'b0; v2 = 1'b0; v8 = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
